ps2_paddle_keys: RTL

Upstream input stage for the pong display controller. It receives the raw PS/2 keyboard clock and data lines and deserialises scan-code set 2 frames. It decodes make and break codes into eight held-key flags that drive the controller's `p1_*` and `p2_*` paddle inputs directly. It also exposes the raw byte stream and a framing-error pulse for debug and for the 7-segment display.

---
 rtl/ps2_paddle_keys.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_paddle_keys.sv
// PS/2 keyboard front end: synchronises and deglitches the PS/2 lines, deserialises set-2 frames
// and turns W/S/A/D and arrow make/break codes into held paddle flags. Optional watchdog: PS2_WATCHDOG_EN.
module ps2_paddle_keys #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p1_left,
    output logic       p1_right,
    output logic       p2_up,
    output logic       p2_down,
    output logic       p2_left,
    output logic       p2_right,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       frame_err
);

    if (FILTER_LEN < 2 || FILTER_LEN > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ps2_paddle_keys: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic       clk_meta_reg, clk_sync_reg;
    logic       data_meta_reg, data_sync_reg;
    logic       filt_level_reg;
    logic [7:0] filt_cnt_reg;
    logic       fall;

    state_t     state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic       parity_reg, parity_next;
    logic [7:0] scancode_reg, scancode_next;
    logic       scancode_valid_reg, scancode_valid_next;
    logic       frame_err_reg, frame_err_next;
    logic       timeout;

    logic       brk_reg, ext_reg;
    logic [7:0] keys_reg;
    logic [7:0] key_sel;

    // Idle PS/2 lines sit high, so the synchronisers reset to 1 as well.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_meta_reg  <= 1'b1;
            clk_sync_reg  <= 1'b1;
            data_meta_reg <= 1'b1;
            data_sync_reg <= 1'b1;
        end else begin
            clk_meta_reg  <= ps2_clk;
            clk_sync_reg  <= clk_meta_reg;
            data_meta_reg <= ps2_data;
            data_sync_reg <= data_meta_reg;
        end
    end

    // The level flips on the FILTER_LEN-th consecutive differing sample.
    assign fall = filt_level_reg && !clk_sync_reg && (filt_cnt_reg == 8'(FILTER_LEN - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_level_reg <= 1'b1;
            filt_cnt_reg   <= '0;
        end else if (clk_sync_reg == filt_level_reg) begin
            filt_cnt_reg <= '0;
        end else if (filt_cnt_reg == 8'(FILTER_LEN - 1)) begin
            filt_level_reg <= clk_sync_reg;
            filt_cnt_reg   <= '0;
        end else begin
            filt_cnt_reg <= filt_cnt_reg + 8'd1;
        end
    end

`ifdef PS2_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_reg;

    // A falling edge in the same cycle wins over an expiring watchdog.
    assign timeout = (state_reg != IDLE) && !fall && (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_reg <= '0;
        end else if (state_reg == IDLE || fall || timeout) begin
            wd_cnt_reg <= '0;
        end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg          <= IDLE;
            bit_cnt_reg        <= '0;
            shift_reg          <= '0;
            parity_reg         <= 1'b0;
            scancode_reg       <= '0;
            scancode_valid_reg <= 1'b0;
            frame_err_reg      <= 1'b0;
        end else begin
            state_reg          <= state_next;
            bit_cnt_reg        <= bit_cnt_next;
            shift_reg          <= shift_next;
            parity_reg         <= parity_next;
            scancode_reg       <= scancode_next;
            scancode_valid_reg <= scancode_valid_next;
            frame_err_reg      <= frame_err_next;
        end
    end

    always_comb begin
        state_next          = state_reg;
        bit_cnt_next        = bit_cnt_reg;
        shift_next          = shift_reg;
        parity_next         = parity_reg;
        scancode_next       = scancode_reg;
        scancode_valid_next = 1'b0;
        frame_err_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fall && !data_sync_reg) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_next   = {data_sync_reg, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_next = data_sync_reg;
                    state_next  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    if (data_sync_reg && (^{shift_reg, parity_reg})) begin
                        scancode_valid_next = 1'b1;
                        scancode_next       = shift_reg;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (timeout) begin
            state_next     = IDLE;
            frame_err_next = 1'b1;
        end
    end

    // key_sel bit order: p1 up/down/left/right, then p2 up/down/left/right.
    always_comb begin
        key_sel = '0;
        case ({ext_reg, scancode_reg})
            9'h01D:  key_sel[0] = 1'b1;
            9'h01B:  key_sel[1] = 1'b1;
            9'h01C:  key_sel[2] = 1'b1;
            9'h023:  key_sel[3] = 1'b1;
            9'h175:  key_sel[4] = 1'b1;
            9'h172:  key_sel[5] = 1'b1;
            9'h16B:  key_sel[6] = 1'b1;
            9'h174:  key_sel[7] = 1'b1;
            default: key_sel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brk_reg <= 1'b0;
            ext_reg <= 1'b0;
        end else if (frame_err_next) begin
            brk_reg <= 1'b0;
            ext_reg <= 1'b0;
        end else if (scancode_valid_reg) begin
            if (scancode_reg == 8'hF0) begin
                brk_reg <= 1'b1;
            end else if (scancode_reg == 8'hE0) begin
                ext_reg <= 1'b1;
            end else begin
                brk_reg <= 1'b0;
                ext_reg <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_key
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                keys_reg[gi] <= 1'b0;
            end else if (scancode_valid_reg && key_sel[gi]) begin
                keys_reg[gi] <= !brk_reg;
            end
        end
    end

    assign p1_up          = keys_reg[0];
    assign p1_down        = keys_reg[1];
    assign p1_left        = keys_reg[2];
    assign p1_right       = keys_reg[3];
    assign p2_up          = keys_reg[4];
    assign p2_down        = keys_reg[5];
    assign p2_left        = keys_reg[6];
    assign p2_right       = keys_reg[7];
    assign scancode       = scancode_reg;
    assign scancode_valid = scancode_valid_reg;
    assign frame_err      = frame_err_reg;

endmodule
